hilo_divide_control: RTL and testbench

Execute-stage controller that sits between the pipeline and the iterative `divider`. It issues DIV/DIVU to the divider and holds the request/operand handshake stable until the result returns. It stalls the pipeline while a live divide is outstanding and owns the architectural HI/LO registers for DIV/DIVU/MTHI/MTLO/MFHI/MFLO. On flush it drains an in-flight divide (the divider has no abort) and discards the result.

---
 rtl/hilo_pkg.sv | 23 ++
 rtl/hilo_divide_control.sv | 136 +++++++++++++
 tb/tb_hilo_divide_control.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op codes, FSM states and defaults for the HI/LO divide controller
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4,
        OP_MFHI = 3'd5,
        OP_MFLO = 3'd6,
        OP_RSVD = 3'd7
    } op_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 40;

endpackage

// File: rtl/hilo_divide_control.sv
// rtl/hilo_divide_control.sv - issues DIV/DIVU to the iterative divider, stalls EX, owns HI/LO
module hilo_divide_control
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_rs,
    input  logic [31:0] op_rt,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] read_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        divide_request_valid,
    output logic        is_signed_input,
    output logic [31:0] input1,
    output logic [31:0] input2,
    input  logic [31:0] divide_result,
    input  logic [31:0] divide_remain,
    input  logic        divide_result_valid,
    output logic        div_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    state_t         state;
    state_t         state_next;
    op_code_t       op;
    logic           is_div;
    logic           accept;
    logic           writeback;
    logic           mt_write;
    logic [CW-1:0]  wait_count;

    assign op     = op_code_t'(op_code);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept     = 1'b0;
        writeback  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid && is_div && !flush) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = !divide_result_valid;
                if (divide_result_valid) begin
                    writeback  = !flush;
                    state_next = ST_IDLE;
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The divider cannot be aborted, so a new divide waits for the drained result.
                stall = op_valid && is_div && !flush;
                if (divide_result_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mt_write = op_valid && !flush && (state != ST_BUSY);

    always_comb begin
        case (op)
            OP_MFHI: read_data = hi;
            OP_MFLO: read_data = lo;
            default: read_data = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            divide_request_valid <= 1'b0;
            is_signed_input      <= 1'b0;
            input1               <= 32'd0;
            input2               <= 32'd1;
        end else if (accept) begin
            divide_request_valid <= 1'b1;
            is_signed_input      <= (op == OP_DIV);
            input1               <= op_rs;
            input2               <= op_rt;
        end else if ((state != ST_IDLE) && divide_result_valid) begin
            divide_request_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (writeback) begin
            lo <= divide_result;
            hi <= divide_remain;
        end else if (mt_write) begin
            if (op == OP_MTHI) hi <= op_rs;
            if (op == OP_MTLO) lo <= op_rs;
        end
    end

    // Saturating wait counter; the flag is sticky while the FSM keeps waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_count  <= '0;
            div_timeout <= 1'b0;
        end else if (state == ST_IDLE) begin
            wait_count <= '0;
        end else if (wait_count != LIMIT) begin
            wait_count <= wait_count + 1'b1;
            if (wait_count == LIMIT - 1'b1) div_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hilo_divide_control.sv
// tb/tb_hilo_divide_control.sv - self-checking bench with a behavioural divider and HI/LO reference
module tb_hilo_divide_control;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_rs;
    logic [31:0] op_rt;
    logic        flush;
    logic        stall;
    logic [31:0] read_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        req;
    logic        is_signed_input;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [31:0] divide_result;
    logic [31:0] divide_remain;
    logic        divide_result_valid;
    logic        div_timeout;

    int checks   = 0;
    int failures = 0;

    int lat   = 4;
    logic never = 1'b0;
    logic [31:0] dcnt;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clock = ~clock;

    hilo_divide_control #(.TIMEOUT_CYCLES(40)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_rs(op_rs), .op_rt(op_rt), .flush(flush), .stall(stall),
        .read_data(read_data), .hi(hi), .lo(lo), .divide_request_valid(req),
        .is_signed_input(is_signed_input), .input1(input1), .input2(input2),
        .divide_result(divide_result), .divide_remain(divide_remain),
        .divide_result_valid(divide_result_valid), .div_timeout(div_timeout)
    );

    // Quotient/remainder of a MIPS-style divide; divide by zero yields all-ones and the dividend.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Divider stand-in: result valid in the lat-th cycle of a held request.
    always @(posedge clock) begin
        if (reset || !req) dcnt <= 32'd0;
        else               dcnt <= dcnt + 32'd1;
    end

    always_comb begin
        logic [31:0] q;
        logic [31:0] r;
        ref_div(is_signed_input, input1, input2, q, r);
        divide_result       = q;
        divide_remain       = r;
        divide_result_valid = req && !never && (dcnt == 32'(lat - 1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic prev_hs = 1'b0;
    always @(negedge clock) begin
        if (prev_hs && !reset) chk("request_gap", {31'd0, req}, 32'd0);
        prev_hs = req && divide_result_valid && !reset;
    end

    // Drives one EX instruction until it leaves EX; returns stall count, first-cycle read_data
    // and whether the divider operands held steady for every cycle the request was high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic fl, output int stalls, output logic [31:0] rd,
                          output logic ops_ok);
        int guard;
        op_valid = 1'b1;
        op_code  = op;
        op_rs    = rs;
        op_rt    = rt;
        flush    = fl;
        stalls   = 0;
        guard    = 0;
        ops_ok   = 1'b1;
        #1;
        rd = read_data;
        while (stall && guard < 200) begin
            if (req && !(input1 == rs && input2 == rt && is_signed_input == (op == 3'd1)))
                ops_ok = 1'b0;
            stalls++;
            guard++;
            @(negedge clock);
            #1;
        end
        if (guard >= 200) chk("stall_timeout", 32'd1, 32'd0);
        if (req && !(input1 == rs && input2 == rt && is_signed_input == (op == 3'd1)))
            ops_ok = 1'b0;
        @(negedge clock);
        op_valid = 1'b0;
        op_code  = 3'd0;
        flush    = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          st;
        logic [31:0] rd;
        logic        ok;
        int          guard;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        fl;
        logic [31:0] q;
        logic [31:0] r;

        vecs[0]  = '{3'd3, 32'h11,        32'h0, 32'h11,        32'h0,        32'h0,        0};
        vecs[1]  = '{3'd4, 32'h22,        32'h0, 32'h11,        32'h22,       32'h0,        0};
        vecs[2]  = '{3'd5, 32'h0,         32'h0, 32'h11,        32'h22,       32'h11,       0};
        vecs[3]  = '{3'd6, 32'h0,         32'h0, 32'h11,        32'h22,       32'h22,       0};
        vecs[4]  = '{3'd1, 32'hFFFFFFF9,  32'h2, 32'hFFFFFFFF,  32'hFFFFFFFD,  32'h0,        4};
        vecs[5]  = '{3'd6, 32'h0,         32'h0, 32'hFFFFFFFF,  32'hFFFFFFFD,  32'hFFFFFFFD, 0};
        vecs[6]  = '{3'd2, 32'hFFFFFFFF,  32'h10, 32'h0000000F, 32'h0FFFFFFF, 32'h0,        4};
        vecs[7]  = '{3'd3, 32'hDEADBEEF,  32'h0, 32'hDEADBEEF,  32'h0FFFFFFF, 32'h0,        0};
        vecs[8]  = '{3'd5, 32'h0,         32'h0, 32'hDEADBEEF,  32'h0FFFFFFF, 32'hDEADBEEF, 0};
        vecs[9]  = '{3'd7, 32'h5,         32'h0, 32'hDEADBEEF,  32'h0FFFFFFF, 32'h0,        0};
        vecs[10] = '{3'd2, 32'h64,        32'h0, 32'h64,        32'hFFFFFFFF, 32'h0,        4};
        vecs[11] = '{3'd1, 32'h64,        32'h7, 32'h2,         32'hE,        32'h0,        4};

        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_rs = 32'd0; op_rt = 32'd0; flush = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_req", {31'd0, req}, 32'd0);
        chk("reset_input1", input1, 32'd0);
        chk("reset_input2", input2, 32'd1);
        chk("reset_signed", {31'd0, is_signed_input}, 32'd0);
        chk("reset_timeout", {31'd0, div_timeout}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);

        lat = 4;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, st, rd, ok);
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            if (vecs[i].op == 3'd1 || vecs[i].op == 3'd2) begin
                chk($sformatf("vec%0d_operands", i), {31'd0, ok}, 32'd1);
                chk($sformatf("vec%0d_req_low", i), {31'd0, req}, 32'd0);
            end
        end

        // Flush three cycles after issue, MTLO and a new DIV arriving while draining.
        lat = 6;
        run_op(3'd3, 32'h11, 32'h0, 1'b0, st, rd, ok);
        run_op(3'd4, 32'h22, 32'h0, 1'b0, st, rd, ok);
        op_valid = 1'b1; op_code = 3'd1; op_rs = 32'd100; op_rt = 32'd7;
        #1;
        chk("flush_issue_stall", {31'd0, stall}, 32'd1);
        repeat (3) @(negedge clock);
        flush = 1'b1;
        #1;
        chk("flush_busy_stall", {31'd0, stall}, 32'd1);
        @(negedge clock);
        flush = 1'b0; op_code = 3'd4; op_rs = 32'h33;
        #1;
        chk("drain_mt_stall", {31'd0, stall}, 32'd0);
        chk("drain_req", {31'd0, req}, 32'd1);
        @(negedge clock);
        op_code = 3'd1; op_rs = 32'd9; op_rt = 32'd2;
        #1;
        chk("drain_mtlo_write", lo, 32'h33);
        chk("drain_div_stall", {31'd0, stall}, 32'd1);
        guard = 0;
        while (req && guard < 20) begin
            @(negedge clock);
            #1;
            guard++;
        end
        chk("drain_req_drops", {31'd0, req}, 32'd0);
        chk("gap_stall", {31'd0, stall}, 32'd1);
        chk("flush_hi_kept", hi, 32'h11);
        chk("flush_lo_kept", lo, 32'h33);
        guard = 0;
        while (stall && guard < 20) begin
            @(negedge clock);
            #1;
            guard++;
        end
        chk("post_drain_div_done", {31'd0, stall}, 32'd0);
        @(negedge clock);
        op_valid = 1'b0; op_code = 3'd0;
        #1;
        chk("post_drain_lo", lo, 32'd4);
        chk("post_drain_hi", hi, 32'd1);

        // Reset while a divide is outstanding.
        op_valid = 1'b1; op_code = 3'd1; op_rs = 32'd50; op_rt = 32'd3;
        repeat (3) @(negedge clock);
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset_req", {31'd0, req}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        chk("midreset_input2", input2, 32'd1);

        // Randomised traffic against the HI/LO reference.
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            rs  = $urandom;
            rt  = $urandom;
            if (rt == 32'd0) rt = 32'd3;
            if (op == 3'd1 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd5;
            fl  = (op == 3'd3 || op == 3'd4) && ($urandom_range(0, 3) == 0);
            lat = $urandom_range(1, 8);
            run_op(op, rs, rt, fl, st, rd, ok);
            case (op)
                3'd1, 3'd2: begin
                    ref_div(op == 3'd1, rs, rt, q, r);
                    m_lo = q;
                    m_hi = r;
                    chk("rand_div_stall", 32'(st), 32'(lat));
                    chk("rand_operands", {31'd0, ok}, 32'd1);
                end
                3'd3: if (!fl) m_hi = rs;
                3'd4: if (!fl) m_lo = rs;
                3'd5: chk("rand_mfhi", rd, m_hi);
                3'd6: chk("rand_mflo", rd, m_lo);
                default: chk("rand_none_rd", rd, 32'd0);
            endcase
            chk("rand_hi", hi, m_hi);
            chk("rand_lo", lo, m_lo);
        end

        // Divider that never answers.
        never = 1'b1;
        op_valid = 1'b1; op_code = 3'd2; op_rs = 32'd10; op_rt = 32'd2;
        @(negedge clock);
        repeat (39) @(negedge clock);
        #1;
        chk("timeout_before", {31'd0, div_timeout}, 32'd0);
        @(negedge clock);
        #1;
        chk("timeout_set", {31'd0, div_timeout}, 32'd1);
        repeat (10) @(negedge clock);
        #1;
        chk("timeout_sticky", {31'd0, div_timeout}, 32'd1);
        chk("timeout_still_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0;
        @(negedge clock);
        reset = 1'b0;
        never = 1'b0;
        #1;
        chk("timeout_cleared", {31'd0, div_timeout}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
